// File: rtl/wb_regfile_pkg.sv
// Shared CPU package for the writeback/register-file slice.
// Holds the architectural data width, register count, the derived register
// index width, the hard-wired zero register index and the retire counter width.
package wb_regfile_pkg;
  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);
  localparam int REG_ZERO  = 0;
  localparam int RET_W     = 32;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB -> register file bus.
// master: pipeline side (drives writeback payload and ID read indices,
//         plus a debug preload hook for the retire counter).
// slave : register file (returns read data, forwarding value, retire count
//         and the most recent committed write).
interface wb_regfile_if #(
  parameter int NREGS = wb_regfile_pkg::NREGS,
  parameter int XLEN  = wb_regfile_pkg::XLEN
);
  localparam int IW = $clog2(NREGS);

  logic            wb_valid;
  logic            reg_write;
  logic            mem_to_reg;
  logic [IW-1:0]   write_reg;
  logic [XLEN-1:0] read_data;
  logic [XLEN-1:0] alu_result;
  logic [IW-1:0]   rs_addr;
  logic [IW-1:0]   rt_addr;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     retired;
  logic [IW-1:0]   last_wr_reg;
  logic [XLEN-1:0] last_wr_data;
  // Debug hook: overwrite the retire count (used to reach the wrap point).
  logic            retired_load;
  logic [31:0]     retired_load_val;

  modport master (
    output wb_valid, reg_write, mem_to_reg, write_reg, read_data, alu_result,
           rs_addr, rt_addr, retired_load, retired_load_val,
    input  rs_data, rt_data, wb_data, retired, last_wr_reg, last_wr_data
  );

  modport slave (
    input  wb_valid, reg_write, mem_to_reg, write_reg, read_data, alu_result,
           rs_addr, rt_addr, retired_load, retired_load_val,
    output rs_data, rt_data, wb_data, retired, last_wr_reg, last_wr_data
  );
endinterface

// File: rtl/wb_retire_counter.sv
// Committed-instruction counter.
// Ports: clk, rst (sync, active high), en (count one), load/load_val
// (debug preload, wins over en), count (wraps silently at all-ones).
module wb_retire_counter import wb_regfile_pkg::*; #(
  parameter int W = RET_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count + W'(1);
  end
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + architectural register file.
// Ports: clk, rst (sync, active high), bus (wb_regfile_if slave):
//   writeback payload in, two combinational read ports with same-cycle
//   write-before-read bypass, wb_data forwarding value, retire count and
//   last committed write (debug).
module wb_regfile import wb_regfile_pkg::*; #(
  parameter int NREGS = wb_regfile_pkg::NREGS,
  parameter int XLEN  = wb_regfile_pkg::XLEN
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam int IW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign bus.wb_data = bus.mem_to_reg ? bus.read_data : bus.alu_result;

  // Reset kills the write, which also kills the bypass below.
  assign wr_en = bus.wb_valid && bus.reg_write &&
                 (bus.write_reg != IW'(REG_ZERO)) && !rst;

  // regs[0] is never written and resets to 0, so x0 reads as 0 without a
  // special case; wr_en never matches index 0 for the bypass either.
  always_comb begin
    bus.rs_data = regs[bus.rs_addr];
    bus.rt_data = regs[bus.rt_addr];
    if (wr_en && (bus.rs_addr == bus.write_reg)) bus.rs_data = bus.wb_data;
    if (wr_en && (bus.rt_addr == bus.write_reg)) bus.rt_data = bus.wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      bus.last_wr_reg  <= '0;
      bus.last_wr_data <= '0;
    end else if (wr_en) begin
      regs[bus.write_reg] <= bus.wb_data;
      bus.last_wr_reg     <= bus.write_reg;
      bus.last_wr_data    <= bus.wb_data;
    end
  end

  wb_retire_counter #(.W(32)) u_retire (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.wb_valid),
    .load     (bus.retired_load),
    .load_val (bus.retired_load_val),
    .count    (bus.retired)
  );
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.NREGS(32), .XLEN(32)) bus ();

  wb_regfile #(.NREGS(32), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state: plain arrays updated from the rules, not from the RTL.
  logic [31:0] mregs [32];
  logic [31:0] mret;
  logic [4:0]  mlr;
  logic [31:0] mld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mret = '0; mlr = '0; mld = '0;
  endtask

  task automatic drive(input logic v, rw, m2r, r, input logic [4:0] wr, ra, rb,
                       input logic [31:0] rd, alu);
    bus.wb_valid = v; bus.reg_write = rw; bus.mem_to_reg = m2r; rst = r;
    bus.write_reg = wr; bus.rs_addr = ra; bus.rt_addr = rb;
    bus.read_data = rd; bus.alu_result = alu;
  endtask

  // One model-checked cycle: comb outputs at negedge, state 1 ns after posedge.
  task automatic mcycle(input logic v, rw, m2r, r, input logic [4:0] wr, ra, rb,
                        input logic [31:0] rd, alu);
    logic [31:0] ewb;
    logic        q;
    drive(v, rw, m2r, r, wr, ra, rb, rd, alu);
    @(negedge clk);
    ewb = m2r ? rd : alu;
    q   = v && rw && (wr != 5'd0) && !r;
    chk("wb_data", bus.wb_data, ewb);
    chk("rs_data", bus.rs_data, (q && ra == wr) ? ewb : mregs[ra]);
    chk("rt_data", bus.rt_data, (q && rb == wr) ? ewb : mregs[rb]);
    @(posedge clk);
    if (r) model_clear();
    else begin
      if (v) mret = mret + 32'd1;
      if (q) begin mregs[wr] = ewb; mlr = wr; mld = ewb; end
    end
    #1;
    chk("retired", bus.retired, mret);
    chk("last_wr_reg", 32'(bus.last_wr_reg), 32'(mlr));
    chk("last_wr_data", bus.last_wr_data, mld);
  endtask

  // Directed vectors, expected values worked out by hand from a zeroed file.
  typedef struct {
    logic v, rw, m2r, r;
    logic [4:0]  wr, ra, rb;
    logic [31:0] rd, alu;
    logic [31:0] e_wb, e_rs, e_rt, e_ret;
    logic [4:0]  e_lr;
    logic [31:0] e_ld;
  } vec_t;
  vec_t vt [8];

  initial begin
    // v rw m2r r | wr ra rb | rd alu | wb rs rt | ret lr ld
    vt[0] = '{1,1,0,0, 5,5,0,  32'h0, 32'hDEADBEEF, 32'hDEADBEEF,32'hDEADBEEF,32'h0, 1, 5,32'hDEADBEEF};
    vt[1] = '{0,0,0,0, 0,5,5,  32'h0, 32'h0,        32'h0,32'hDEADBEEF,32'hDEADBEEF, 1, 5,32'hDEADBEEF};
    vt[2] = '{1,1,1,0, 0,0,0,  32'h12345678, 32'h0, 32'h12345678,32'h0,32'h0,   2, 5,32'hDEADBEEF};
    vt[3] = '{0,1,0,0, 7,7,7,  32'h0, 32'hFFFF,     32'hFFFF,32'h0,32'h0,       2, 5,32'hDEADBEEF};
    vt[4] = '{0,0,0,0, 0,7,5,  32'h0, 32'h0,        32'h0,32'h0,32'hDEADBEEF,   2, 5,32'hDEADBEEF};
    vt[5] = '{1,1,0,0, 9,9,9,  32'h0, 32'h0BADF00D, 32'h0BADF00D,32'h0BADF00D,32'h0BADF00D, 3, 9,32'h0BADF00D};
    vt[6] = '{1,1,0,1, 3,3,9,  32'h0, 32'hAA,       32'hAA,32'h0,32'h0BADF00D,  0, 0,32'h0};
    vt[7] = '{0,0,0,0, 0,3,9,  32'h0, 32'h0,        32'h0,32'h0,32'h0,          0, 0,32'h0};

    bus.retired_load = 1'b0; bus.retired_load_val = '0;
    drive(0,0,0,1, 0,0,0, 0,0);
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("reset retired", bus.retired, 32'h0);
    chk("reset last_wr_reg", 32'(bus.last_wr_reg), 32'h0);
    chk("reset last_wr_data", bus.last_wr_data, 32'h0);

    // Every address reads zero after reset.
    for (int i = 0; i < 32; i++)
      mcycle(0,0,0,0, 5'(i), 5'(i), 5'(31 - i), 32'h0, 32'h0);

    // Directed table.
    for (int k = 0; k < 8; k++) begin
      drive(vt[k].v, vt[k].rw, vt[k].m2r, vt[k].r, vt[k].wr, vt[k].ra, vt[k].rb,
            vt[k].rd, vt[k].alu);
      @(negedge clk);
      chk($sformatf("vec%0d wb_data", k), bus.wb_data, vt[k].e_wb);
      chk($sformatf("vec%0d rs_data", k), bus.rs_data, vt[k].e_rs);
      chk($sformatf("vec%0d rt_data", k), bus.rt_data, vt[k].e_rt);
      @(posedge clk); #1;
      chk($sformatf("vec%0d retired", k), bus.retired, vt[k].e_ret);
      chk($sformatf("vec%0d last_wr_reg", k), 32'(bus.last_wr_reg), 32'(vt[k].e_lr));
      chk($sformatf("vec%0d last_wr_data", k), bus.last_wr_data, vt[k].e_ld);
    end
    model_clear();

    // Retire counter wrap via preload hook.
    drive(0,0,0,0, 0,0,0, 0,0);
    bus.retired_load = 1'b1; bus.retired_load_val = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.retired_load = 1'b0;
    chk("preload retired", bus.retired, 32'hFFFFFFFF);
    mret = 32'hFFFFFFFF;
    mcycle(1,0,0,0, 4,4,4, 32'h0, 32'h55);
    chk("wrap retired", bus.retired, 32'h0);

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr, ra, rb;
      wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      mcycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
             wr, ra, rb, $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
